// File: rtl/ms_dual_source_if.sv
// Bundle for ms_dual_source: the upstream accept handshake, both master data channels,
// and the shared-variable exchange with the downstream block.
interface ms_dual_source_if;
  logic signed [31:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] s_out;
  logic               s_out_sync;
  logic signed [31:0] s_out2;
  logic               s_out2_sync;
  logic signed [31:0] sh_in;
  logic signed [31:0] sh_out;
  logic        [7:0]  drop_cnt;

  // The block itself drives both master channels.
  modport master (
    input  in_data, in_valid, sh_in,
    output in_ready, s_out, s_out_sync, s_out2, s_out2_sync, sh_out, drop_cnt
  );

  // The producer and downstream side.
  modport slave (
    output in_data, in_valid, sh_in,
    input  in_ready, s_out, s_out_sync, s_out2, s_out2_sync, sh_out, drop_cnt
  );
endinterface

// File: rtl/ms_dual_source.sv
// Dual-write master source: accepts one value, publishes it on s_out/sh_out, and then,
// after GAP idle cycles, publishes the value plus the downstream shared variable on s_out2.
module ms_dual_source #(
  parameter int GAP = 2
) (
  input  logic            clk,
  input  logic            rst,
  ms_dual_source_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    WAIT  = 2'd2,
    EMIT2 = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? 8'hFF : (cnt + 8'd1);
  endfunction

  state_t             state_r;
  logic signed [31:0] val_r;
  logic        [3:0]  wait_cnt_r;
  logic               in_ready_r;
  logic signed [31:0] s_out_r;
  logic               s_out_sync_r;
  logic signed [31:0] s_out2_r;
  logic               s_out2_sync_r;
  logic signed [31:0] sh_out_r;
  logic        [7:0]  drop_cnt_r;

  // Transaction FSM together with every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      val_r         <= 32'sd0;
      wait_cnt_r    <= 4'd0;
      in_ready_r    <= 1'b0;
      s_out_r       <= 32'sd0;
      s_out_sync_r  <= 1'b0;
      s_out2_r      <= 32'sd0;
      s_out2_sync_r <= 1'b0;
      sh_out_r      <= 32'sd0;
      drop_cnt_r    <= 8'd0;
    end else begin
      s_out_sync_r  <= 1'b0;
      s_out2_sync_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // in_ready rises one cycle after IDLE is entered, so it is only seen high while idle.
          if (bus.in_valid && in_ready_r) begin
            val_r      <= bus.in_data;
            in_ready_r <= 1'b0;
            state_r    <= EMIT1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        EMIT1: begin
          s_out_r      <= val_r;
          s_out_sync_r <= 1'b1;
          sh_out_r     <= val_r;
          if (val_r[31]) begin
            drop_cnt_r <= sat_inc8(drop_cnt_r);
            state_r    <= IDLE;
          end else if (GAP > 0) begin
            wait_cnt_r <= GAP_LOAD;
            state_r    <= WAIT;
          end else begin
            state_r    <= EMIT2;
          end
        end
        WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r <= EMIT2;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        EMIT2: begin
          s_out2_r      <= val_r + bus.sh_in;
          s_out2_sync_r <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.s_out       = s_out_r;
  assign bus.s_out_sync  = s_out_sync_r;
  assign bus.s_out2      = s_out2_r;
  assign bus.s_out2_sync = s_out2_sync_r;
  assign bus.sh_out      = sh_out_r;
  assign bus.drop_cnt    = drop_cnt_r;

endmodule
